// File: rtl/mcfsm_pkg.sv
// Shared encodings for the multi-cycle control FSM: state codes, opcodes,
// ALU operation codes and ALU source-B selector codes.
package mcfsm_pkg;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_EXEC_I   = 4'd4,
      S_ALU_WB   = 4'd5,
      S_IMM_WB   = 4'd6,
      S_MEM_ADDR = 4'd7,
      S_MEM_RD   = 4'd8,
      S_MEM_WB   = 4'd9,
      S_MEM_WR   = 4'd10,
      S_BRANCH   = 4'd11,
      S_JUMP     = 4'd12,
      S_TRAP     = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b000001;
   localparam logic [5:0] OP_LW    = 6'b000100;
   localparam logic [5:0] OP_SW    = 6'b000101;
   localparam logic [5:0] OP_BEQ   = 6'b000110;
   localparam logic [5:0] OP_J     = 6'b000111;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;

   localparam logic [1:0] SRCB_REGB   = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle instruction sequencer: steps each instruction through fetch/decode/execute/
// memory/write-back, drives datapath strobes per state and traps on timeout or bad opcode.
module multicycle_control_fsm
   import mcfsm_pkg::*;
#(
   parameter int OPW         = 6,
   parameter int ALUOPW      = 3,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [OPW-1:0]    opcode,
   input  logic              mem_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic              iord,
   output logic              ir_write,
   output logic              pc_write,
   output logic              branch,
   output logic              jump,
   output logic              alu_src_a,
   output logic [1:0]        alu_src_b,
   output logic [ALUOPW-1:0] alu_op,
   output logic              reg_dst,
   output logic              mem_to_reg,
   output logic              reg_write,
   output logic              instr_done,
   output logic              illegal_op,
   output logic              bus_err,
   output logic              halted,
   output logic [3:0]        state_o
);

   localparam int CNTW = $clog2(MEM_TIMEOUT + 1);

   state_t          state_r;
   state_t          next_state_s;
   logic [CNTW-1:0] wait_cnt_r;
   logic            mem_wait_s;
   logic            timeout_s;
   state_t          after_done_s;

   // The counter holds the low-ready cycles already spent, so the limit is hit on the
   // MEM_TIMEOUT-th consecutive low cycle.
   always_comb begin
      mem_wait_s   = (state_r == S_FETCH) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR);
      timeout_s    = mem_wait_s && !mem_ready && (wait_cnt_r == CNTW'(MEM_TIMEOUT - 1));
      after_done_s = run ? S_FETCH : S_IDLE;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Wait-state counter: cleared on any state change, on ready, or outside memory states
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_r <= '0;
      end else if ((next_state_s != state_r) || mem_ready || !mem_wait_s) begin
         wait_cnt_r <= '0;
      end else begin
         wait_cnt_r <= wait_cnt_r + CNTW'(1);
      end
   end

   // Next-state and per-state datapath strobes
   always_comb begin
      next_state_s = state_r;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      iord         = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      branch       = 1'b0;
      jump         = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = SRCB_REGB;
      alu_op       = ALUOPW'(ALU_ADD);
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      reg_write    = 1'b0;
      instr_done   = 1'b0;
      illegal_op   = 1'b0;
      bus_err      = 1'b0;
      halted       = 1'b0;
      case (state_r)
         S_IDLE: begin
            next_state_s = run ? S_FETCH : S_IDLE;
         end
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRCB_FOUR;
            if (mem_ready) begin
               ir_write     = 1'b1;
               pc_write     = 1'b1;
               next_state_s = S_DECODE;
            end else if (timeout_s) begin
               bus_err      = 1'b1;
               next_state_s = S_TRAP;
            end else begin
               next_state_s = S_FETCH;
            end
         end
         S_DECODE: begin
            alu_src_b = SRCB_IMM_SH;
            case (opcode)
               OP_RTYPE: next_state_s = S_EXEC_R;
               OP_ADDI:  next_state_s = S_EXEC_I;
               OP_LW:    next_state_s = S_MEM_ADDR;
               OP_SW:    next_state_s = S_MEM_ADDR;
               OP_BEQ:   next_state_s = S_BRANCH;
               OP_J:     next_state_s = S_JUMP;
               default: begin
                  illegal_op   = 1'b1;
                  next_state_s = S_TRAP;
               end
            endcase
         end
         S_EXEC_R: begin
            alu_src_a    = 1'b1;
            alu_op       = ALUOPW'(ALU_FUNCT);
            next_state_s = S_ALU_WB;
         end
         S_EXEC_I: begin
            alu_src_a    = 1'b1;
            alu_src_b    = SRCB_IMM;
            next_state_s = S_IMM_WB;
         end
         S_ALU_WB: begin
            reg_dst      = 1'b1;
            reg_write    = 1'b1;
            instr_done   = 1'b1;
            next_state_s = after_done_s;
         end
         S_IMM_WB: begin
            reg_write    = 1'b1;
            instr_done   = 1'b1;
            next_state_s = after_done_s;
         end
         S_MEM_ADDR: begin
            alu_src_a    = 1'b1;
            alu_src_b    = SRCB_IMM;
            next_state_s = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               next_state_s = S_MEM_WB;
            end else if (timeout_s) begin
               bus_err      = 1'b1;
               next_state_s = S_TRAP;
            end else begin
               next_state_s = S_MEM_RD;
            end
         end
         S_MEM_WB: begin
            mem_to_reg   = 1'b1;
            reg_write    = 1'b1;
            instr_done   = 1'b1;
            next_state_s = after_done_s;
         end
         S_MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               instr_done   = 1'b1;
               next_state_s = after_done_s;
            end else if (timeout_s) begin
               bus_err      = 1'b1;
               next_state_s = S_TRAP;
            end else begin
               next_state_s = S_MEM_WR;
            end
         end
         S_BRANCH: begin
            alu_src_a    = 1'b1;
            alu_op       = ALUOPW'(ALU_SUB);
            branch       = 1'b1;
            instr_done   = 1'b1;
            next_state_s = after_done_s;
         end
         S_JUMP: begin
            jump         = 1'b1;
            pc_write     = 1'b1;
            instr_done   = 1'b1;
            next_state_s = after_done_s;
         end
         S_TRAP: begin
            halted       = 1'b1;
            next_state_s = S_TRAP;
         end
         default: begin
            next_state_s = S_IDLE;
         end
      endcase
   end

   assign state_o = state_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-scenario tasks compare state and all
// strobes each cycle against hand-derived constants.
module tb_multicycle_control_fsm;
   import mcfsm_pkg::*;

   logic       clk = 1'b0;
   logic       rst, run, mem_ready;
   logic [5:0] opcode;
   logic       mem_req, mem_we, iord, ir_write, pc_write, branch, jump, alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal_op, bus_err, halted;
   logic [3:0] state_o;
   logic [19:0] outs;
   int nvec = 0;
   int nerr = 0;

   // Field order: mem_req mem_we iord ir_write pc_write branch jump src_a src_b alu_op
   //              reg_dst mem_to_reg reg_write instr_done illegal_op bus_err halted
   localparam logic [19:0] E_ZERO     = 20'b0_0_0_0_0_0_0_0_00_000_0_0_0_0_0_0_0;
   localparam logic [19:0] E_FETCH_R  = 20'b1_0_0_1_1_0_0_0_01_000_0_0_0_0_0_0_0;
   localparam logic [19:0] E_FETCH_W  = 20'b1_0_0_0_0_0_0_0_01_000_0_0_0_0_0_0_0;
   localparam logic [19:0] E_FETCH_TO = 20'b1_0_0_0_0_0_0_0_01_000_0_0_0_0_0_1_0;
   localparam logic [19:0] E_DECODE   = 20'b0_0_0_0_0_0_0_0_11_000_0_0_0_0_0_0_0;
   localparam logic [19:0] E_DEC_ILL  = 20'b0_0_0_0_0_0_0_0_11_000_0_0_0_0_1_0_0;
   localparam logic [19:0] E_EXEC_R   = 20'b0_0_0_0_0_0_0_1_00_010_0_0_0_0_0_0_0;
   localparam logic [19:0] E_EXEC_I   = 20'b0_0_0_0_0_0_0_1_10_000_0_0_0_0_0_0_0;
   localparam logic [19:0] E_ALU_WB   = 20'b0_0_0_0_0_0_0_0_00_000_1_0_1_1_0_0_0;
   localparam logic [19:0] E_IMM_WB   = 20'b0_0_0_0_0_0_0_0_00_000_0_0_1_1_0_0_0;
   localparam logic [19:0] E_MEM_RD   = 20'b1_0_1_0_0_0_0_0_00_000_0_0_0_0_0_0_0;
   localparam logic [19:0] E_MEM_WB   = 20'b0_0_0_0_0_0_0_0_00_000_0_1_1_1_0_0_0;
   localparam logic [19:0] E_MEM_WR_W = 20'b1_1_1_0_0_0_0_0_00_000_0_0_0_0_0_0_0;
   localparam logic [19:0] E_MEM_WR_R = 20'b1_1_1_0_0_0_0_0_00_000_0_0_0_1_0_0_0;
   localparam logic [19:0] E_BRANCH   = 20'b0_0_0_0_0_1_0_1_00_001_0_0_0_1_0_0_0;
   localparam logic [19:0] E_JUMP     = 20'b0_0_0_0_1_0_1_0_00_000_0_0_0_1_0_0_0;
   localparam logic [19:0] E_TRAP     = 20'b0_0_0_0_0_0_0_0_00_000_0_0_0_0_0_0_1;

   multicycle_control_fsm #(.OPW(6), .ALUOPW(3), .MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
      .pc_write(pc_write), .branch(branch), .jump(jump), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .instr_done(instr_done), .illegal_op(illegal_op),
      .bus_err(bus_err), .halted(halted), .state_o(state_o)
   );

   assign outs = {mem_req, mem_we, iord, ir_write, pc_write, branch, jump, alu_src_a,
                  alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, instr_done,
                  illegal_op, bus_err, halted};

   always #5 clk = ~clk;

   // Inputs change at edge+1; the following #1 lets combinational outputs settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = 6'b000000;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; run = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;
      step(); step(); #1;
      nvec++; if ({state_o, outs} !== {S_IDLE, E_ZERO}) begin nerr++; $display("FAIL reset_hold: got %h exp %h", {state_o, outs}, {S_IDLE, E_ZERO}); end
      rst = 1'b0; run = 1'b0; #1;
      nvec++; if ({state_o, outs} !== {S_IDLE, E_ZERO}) begin nerr++; $display("FAIL reset_idle: got %h exp %h", {state_o, outs}, {S_IDLE, E_ZERO}); end
   endtask

   task automatic test_rtype();
      run = 1'b1; mem_ready = 1'b1; opcode = 6'b000000; step(); #1;
      nvec++; if ({state_o, outs} !== {S_FETCH, E_FETCH_R}) begin nerr++; $display("FAIL r_fetch: got %h exp %h", {state_o, outs}, {S_FETCH, E_FETCH_R}); end
      step(); #1;
      nvec++; if ({state_o, outs} !== {S_DECODE, E_DECODE}) begin nerr++; $display("FAIL r_decode: got %h exp %h", {state_o, outs}, {S_DECODE, E_DECODE}); end
      step(); #1;
      nvec++; if ({state_o, outs} !== {S_EXEC_R, E_EXEC_R}) begin nerr++; $display("FAIL r_exec: got %h exp %h", {state_o, outs}, {S_EXEC_R, E_EXEC_R}); end
      step(); run = 1'b0; #1;
      nvec++; if ({state_o, outs} !== {S_ALU_WB, E_ALU_WB}) begin nerr++; $display("FAIL r_wb: got %h exp %h", {state_o, outs}, {S_ALU_WB, E_ALU_WB}); end
      step(); #1;
      nvec++; if ({state_o, outs} !== {S_IDLE, E_ZERO}) begin nerr++; $display("FAIL r_idle: got %h exp %h", {state_o, outs}, {S_IDLE, E_ZERO}); end
   endtask

   task automatic test_lw_wait();
      run = 1'b1; mem_ready = 1'b1; opcode = 6'b000100; step(); step(); step(); #1;
      nvec++; if ({state_o, outs} !== {S_MEM_ADDR, E_EXEC_I}) begin nerr++; $display("FAIL lw_addr: got %h exp %h", {state_o, outs}, {S_MEM_ADDR, E_EXEC_I}); end
      for (int i = 0; i < 4; i++) begin
         step(); mem_ready = (i == 3); #1;
         nvec++; if ({state_o, outs} !== {S_MEM_RD, E_MEM_RD}) begin nerr++; $display("FAIL lw_rd%0d: got %h exp %h", i, {state_o, outs}, {S_MEM_RD, E_MEM_RD}); end
      end
      step(); #1;
      nvec++; if ({state_o, outs} !== {S_MEM_WB, E_MEM_WB}) begin nerr++; $display("FAIL lw_wb: got %h exp %h", {state_o, outs}, {S_MEM_WB, E_MEM_WB}); end
      step(); #1;
      nvec++; if ({state_o, outs} !== {S_FETCH, E_FETCH_R}) begin nerr++; $display("FAIL lw_next: got %h exp %h", {state_o, outs}, {S_FETCH, E_FETCH_R}); end
      // Second LW is aborted by reset while waiting in MEM_RD
      step(); step(); step(); mem_ready = 1'b0; rst = 1'b1; #1;
      nvec++; if ({state_o, outs} !== {S_MEM_RD, E_MEM_RD}) begin nerr++; $display("FAIL lw2_rd: got %h exp %h", {state_o, outs}, {S_MEM_RD, E_MEM_RD}); end
      step(); #1;
      nvec++; if ({state_o, outs} !== {S_IDLE, E_ZERO}) begin nerr++; $display("FAIL lw_abort: got %h exp %h", {state_o, outs}, {S_IDLE, E_ZERO}); end
      rst = 1'b0; run = 1'b0;
   endtask

   task automatic test_addi_sw();
      run = 1'b1; mem_ready = 1'b1; opcode = 6'b000001; step(); step(); step(); #1;
      nvec++; if ({state_o, outs} !== {S_EXEC_I, E_EXEC_I}) begin nerr++; $display("FAIL addi_exec: got %h exp %h", {state_o, outs}, {S_EXEC_I, E_EXEC_I}); end
      step(); #1;
      nvec++; if ({state_o, outs} !== {S_IMM_WB, E_IMM_WB}) begin nerr++; $display("FAIL addi_wb: got %h exp %h", {state_o, outs}, {S_IMM_WB, E_IMM_WB}); end
      step(); opcode = 6'b000101; step(); step(); step(); mem_ready = 1'b0; #1;
      nvec++; if ({state_o, outs} !== {S_MEM_WR, E_MEM_WR_W}) begin nerr++; $display("FAIL sw_wait: got %h exp %h", {state_o, outs}, {S_MEM_WR, E_MEM_WR_W}); end
      step(); mem_ready = 1'b1; run = 1'b0; #1;
      nvec++; if ({state_o, outs} !== {S_MEM_WR, E_MEM_WR_R}) begin nerr++; $display("FAIL sw_done: got %h exp %h", {state_o, outs}, {S_MEM_WR, E_MEM_WR_R}); end
      step(); #1;
      nvec++; if ({state_o, outs} !== {S_IDLE, E_ZERO}) begin nerr++; $display("FAIL sw_idle: got %h exp %h", {state_o, outs}, {S_IDLE, E_ZERO}); end
   endtask

   task automatic test_back_to_back();
      run = 1'b1; mem_ready = 1'b1; opcode = 6'b000110; step(); step(); step(); #1;
      nvec++; if ({state_o, outs} !== {S_BRANCH, E_BRANCH}) begin nerr++; $display("FAIL beq: got %h exp %h", {state_o, outs}, {S_BRANCH, E_BRANCH}); end
      step(); opcode = 6'b000111; #1;
      nvec++; if ({state_o, outs} !== {S_FETCH, E_FETCH_R}) begin nerr++; $display("FAIL j_fetch: got %h exp %h", {state_o, outs}, {S_FETCH, E_FETCH_R}); end
      step(); step(); run = 1'b0; #1;
      nvec++; if ({state_o, outs} !== {S_JUMP, E_JUMP}) begin nerr++; $display("FAIL jump: got %h exp %h", {state_o, outs}, {S_JUMP, E_JUMP}); end
      step(); #1;
      nvec++; if ({state_o, outs} !== {S_IDLE, E_ZERO}) begin nerr++; $display("FAIL j_idle: got %h exp %h", {state_o, outs}, {S_IDLE, E_ZERO}); end
   endtask

   task automatic test_ready_wins();
      run = 1'b1; mem_ready = 1'b0; opcode = 6'b000000; step();
      for (int i = 1; i <= 15; i++) begin
         mem_ready = (i == 15); #1;
         if (i == 15) begin
            nvec++; if ({state_o, outs} !== {S_FETCH, E_FETCH_R}) begin nerr++; $display("FAIL ready_wins: got %h exp %h", {state_o, outs}, {S_FETCH, E_FETCH_R}); end
         end else begin
            nvec++; if ({state_o, outs} !== {S_FETCH, E_FETCH_W}) begin nerr++; $display("FAIL rw_wait%0d: got %h exp %h", i, {state_o, outs}, {S_FETCH, E_FETCH_W}); end
         end
         step();
      end
      #1;
      nvec++; if ({state_o, outs} !== {S_DECODE, E_DECODE}) begin nerr++; $display("FAIL rw_decode: got %h exp %h", {state_o, outs}, {S_DECODE, E_DECODE}); end
      do_reset();
   endtask

   task automatic test_timeout();
      run = 1'b1; mem_ready = 1'b0; step();
      for (int i = 1; i <= 14; i++) step();
      #1;
      nvec++; if ({state_o, outs} !== {S_FETCH, E_FETCH_TO}) begin nerr++; $display("FAIL bus_err: got %h exp %h", {state_o, outs}, {S_FETCH, E_FETCH_TO}); end
      step(); #1;
      nvec++; if ({state_o, outs} !== {S_TRAP, E_TRAP}) begin nerr++; $display("FAIL to_trap: got %h exp %h", {state_o, outs}, {S_TRAP, E_TRAP}); end
      do_reset();
   endtask

   task automatic test_illegal();
      run = 1'b1; mem_ready = 1'b1; opcode = 6'b110001; step(); step(); #1;
      nvec++; if ({state_o, outs} !== {S_DECODE, E_DEC_ILL}) begin nerr++; $display("FAIL illegal: got %h exp %h", {state_o, outs}, {S_DECODE, E_DEC_ILL}); end
      for (int i = 0; i < 3; i++) begin
         step(); mem_ready = i[0]; #1;
         nvec++; if ({state_o, outs} !== {S_TRAP, E_TRAP}) begin nerr++; $display("FAIL trap_hold%0d: got %h exp %h", i, {state_o, outs}, {S_TRAP, E_TRAP}); end
      end
      do_reset(); #1;
      nvec++; if ({state_o, outs} !== {S_IDLE, E_ZERO}) begin nerr++; $display("FAIL trap_exit: got %h exp %h", {state_o, outs}, {S_IDLE, E_ZERO}); end
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = 6'b000000;
      test_reset();
      test_rtype();
      test_lw_wait();
      test_addi_sw();
      test_back_to_back();
      test_ready_wins();
      test_timeout();
      test_illegal();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
